// File: rtl/bundling_acc_if.sv
// Handshake bundle between the binding stage, the bundling accumulator and its consumer.
interface bundling_acc_if #(
    parameter int unsigned HV_LENGTH = 2048,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned ITEM_W    = 16
);
    logic [HV_LENGTH-1:0] bind_hv_in;
    logic                 bind_valid;
    logic                 bind_last;
    logic [CNT_W-1:0]     threshold;
    logic [HV_LENGTH-1:0] bundle_hv_out;
    logic                 bundle_valid;
    logic                 bundle_ack;
    logic                 busy;
    logic [ITEM_W-1:0]    item_count;
    logic                 drop_err;

    modport master (
        output bind_hv_in, bind_valid, bind_last, threshold, bundle_ack,
        input  bundle_hv_out, bundle_valid, busy, item_count, drop_err
    );

    modport slave (
        input  bind_hv_in, bind_valid, bind_last, threshold, bundle_ack,
        output bundle_hv_out, bundle_valid, busy, item_count, drop_err
    );
endinterface

// File: rtl/bundling_acc.sv
// Bundling stage: accumulates bound HVs into per-dimension saturating counters and
// thresholds them into a binary bundled HV held until the consumer acknowledges it.
module bundling_acc #(
    parameter int unsigned HV_LENGTH = 2048,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned ITEM_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 soft_reset,
    bundling_acc_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, THRESH, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q [HV_LENGTH];
    logic [CNT_W-1:0]     cnt_d [HV_LENGTH];
    logic [HV_LENGTH-1:0] hv_q, hv_d;
    logic                 valid_q, valid_d;
    logic [ITEM_W-1:0]    item_q, item_d;
    logic                 drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hv_d    = hv_q;
        valid_d = valid_q;
        item_d  = item_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (bus.bind_valid) begin
                    for (int unsigned i = 0; i < HV_LENGTH; i++) begin
                        if (bus.bind_hv_in[i] && (cnt_q[i] != '1))
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                    if (item_q != '1)
                        item_d = item_q + ITEM_W'(1);
                    state_d = bus.bind_last ? THRESH : ACCUM;
                end
            end
            THRESH: begin
                for (int unsigned i = 0; i < HV_LENGTH; i++)
                    hv_d[i] = (cnt_q[i] >= bus.threshold);
                valid_d = 1'b1;
                state_d = DONE;
                if (bus.bind_valid)
                    drop_d = 1'b1;
            end
            DONE: begin
                if (bus.bind_valid)
                    drop_d = 1'b1;
                // Output register keeps its value across the ack; only the accumulator clears.
                if (bus.bundle_ack) begin
                    valid_d = 1'b0;
                    cnt_d   = '{default: '0};
                    item_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !soft_reset) begin
            state_q <= IDLE;
            cnt_q   <= '{default: '0};
            hv_q    <= '0;
            valid_q <= 1'b0;
            item_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hv_q    <= hv_d;
            valid_q <= valid_d;
            item_q  <= item_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.bundle_hv_out = hv_q;
    assign bus.bundle_valid  = valid_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.item_count    = item_q;
    assign bus.drop_err      = drop_q;
endmodule

// File: tb/tb_bundling_acc.sv
// Scoreboard bench for bundling_acc with an 8-bit hypervector.
module tb_bundling_acc;
    localparam int unsigned HVL = 8;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic soft_reset = 1'b1;

    bundling_acc_if #(.HV_LENGTH(HVL), .CNT_W(4), .ITEM_W(16)) b ();

    bundling_acc #(.HV_LENGTH(HVL), .CNT_W(4), .ITEM_W(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .soft_reset (soft_reset),
        .bus        (b.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HVL-1:0] hv;
        logic [15:0]    items;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;

    task automatic send(input logic [HVL-1:0] hv, input logic last);
        @(negedge clk);
        b.bind_hv_in = hv;
        b.bind_valid = 1'b1;
        b.bind_last  = last;
        @(negedge clk);
        b.bind_valid = 1'b0;
        b.bind_last  = 1'b0;
    endtask

    task automatic wait_valid(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (b.bundle_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack();
        @(negedge clk);
        b.bundle_ack = 1'b1;
        @(negedge clk);
        b.bundle_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (b.bundle_valid !== 1'b0 || b.busy !== 1'b0 || b.bundle_hv_out !== 8'h00 ||
            b.item_count !== 16'd0 || b.drop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b busy=%b hv=%h items=%0d drop=%b exp all zero",
                     b.bundle_valid, b.busy, b.bundle_hv_out, b.item_count, b.drop_err);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_majority();
        bit to;
        b.threshold = 4'd2;
        send(8'b0000_0111, 1'b0);
        send(8'b0000_0110, 1'b0);
        sb.push_back('{hv: 8'b0000_0110, items: 16'd3});
        send(8'b0000_1100, 1'b1);
        wait_valid(to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL majority_timeout got valid=0 exp valid=1"); end
        e = sb.pop_front();
        vectors++;
        if (b.bundle_hv_out !== e.hv || b.item_count !== e.items) begin
            miscompares++;
            $display("FAIL majority_result got hv=%h items=%0d exp hv=%h items=%0d",
                     b.bundle_hv_out, b.item_count, e.hv, e.items);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (b.bundle_valid !== 1'b1 || b.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL majority_hold got v=%b busy=%b exp 1 1", b.bundle_valid, b.busy);
        end
        ack();
        vectors++;
        if (b.bundle_valid !== 1'b0 || b.busy !== 1'b0 || b.item_count !== 16'd0 ||
            b.bundle_hv_out !== 8'b0000_0110) begin
            miscompares++;
            $display("FAIL majority_ack got v=%b busy=%b items=%0d hv=%h exp 0 0 0 06",
                     b.bundle_valid, b.busy, b.item_count, b.bundle_hv_out);
        end
    endtask

    task automatic test_saturation();
        bit to;
        int n_items [2] = '{20, 14};
        logic [HVL-1:0] exp_hv [2] = '{8'hFF, 8'h00};
        b.threshold = 4'd15;
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= n_items[r]; k++) begin
                if (k == n_items[r])
                    sb.push_back('{hv: exp_hv[r], items: 16'(n_items[r])});
                send(8'hFF, k == n_items[r]);
            end
            wait_valid(to);
            vectors++;
            if (to) begin miscompares++; $display("FAIL sat_timeout run=%0d got valid=0 exp 1", r); end
            e = sb.pop_front();
            vectors++;
            if (b.bundle_hv_out !== e.hv || b.item_count !== e.items) begin
                miscompares++;
                $display("FAIL sat_result run=%0d got hv=%h items=%0d exp hv=%h items=%0d",
                         r, b.bundle_hv_out, b.item_count, e.hv, e.items);
            end
            ack();
        end
    endtask

    task automatic test_single();
        bit to;
        logic [3:0]     thr [2] = '{4'd1, 4'd0};
        logic [HVL-1:0] hv  [2] = '{8'hA5, 8'h00};
        logic [HVL-1:0] exp [2] = '{8'hA5, 8'hFF};
        for (int r = 0; r < 2; r++) begin
            b.threshold = thr[r];
            sb.push_back('{hv: exp[r], items: 16'd1});
            send(hv[r], 1'b1);
            vectors++;
            if (b.busy !== 1'b1 || b.bundle_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL single_thresh_cycle run=%0d got busy=%b v=%b exp 1 0",
                         r, b.busy, b.bundle_valid);
            end
            @(negedge clk);
            vectors++;
            if (b.bundle_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL single_latency run=%0d got v=%b exp 1", r, b.bundle_valid);
            end
            wait_valid(to);
            e = sb.pop_front();
            vectors++;
            if (to || b.bundle_hv_out !== e.hv || b.item_count !== e.items) begin
                miscompares++;
                $display("FAIL single_result run=%0d got hv=%h items=%0d exp hv=%h items=%0d",
                         r, b.bundle_hv_out, b.item_count, e.hv, e.items);
            end
            ack();
        end
    endtask

    task automatic test_drop();
        bit to;
        b.threshold = 4'd1;
        sb.push_back('{hv: 8'h3C, items: 16'd1});
        send(8'h3C, 1'b1);
        wait_valid(to);
        e = sb.pop_front();
        vectors++;
        if (to || b.bundle_hv_out !== e.hv || b.drop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_first got hv=%h drop=%b exp hv=%h drop=0", b.bundle_hv_out, b.drop_err, e.hv);
        end
        send(8'hFF, 1'b0);
        vectors++;
        if (b.drop_err !== 1'b1 || b.bundle_hv_out !== 8'h3C || b.item_count !== 16'd1 ||
            b.bundle_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_in_done got drop=%b hv=%h items=%0d v=%b exp 1 3c 1 1",
                     b.drop_err, b.bundle_hv_out, b.item_count, b.bundle_valid);
        end
        ack();
        sb.push_back('{hv: 8'h01, items: 16'd1});
        send(8'h01, 1'b1);
        wait_valid(to);
        e = sb.pop_front();
        vectors++;
        if (to || b.bundle_hv_out !== e.hv || b.drop_err !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_next_bundle got hv=%h drop=%b exp hv=%h drop=1", b.bundle_hv_out, b.drop_err, e.hv);
        end
        ack();
        @(negedge clk);
        soft_reset = 1'b0;
        @(negedge clk);
        soft_reset = 1'b1;
        vectors++;
        if (b.drop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_clear got drop=%b exp 0", b.drop_err);
        end
    endtask

    task automatic test_soft_reset();
        bit to;
        b.threshold = 4'd1;
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        soft_reset = 1'b0;
        @(negedge clk);
        soft_reset = 1'b1;
        vectors++;
        if (b.busy !== 1'b0 || b.item_count !== 16'd0 || b.bundle_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL soft_reset_state got busy=%b items=%0d v=%b exp 0 0 0",
                     b.busy, b.item_count, b.bundle_valid);
        end
        sb.push_back('{hv: 8'h81, items: 16'd1});
        send(8'h81, 1'b1);
        wait_valid(to);
        e = sb.pop_front();
        vectors++;
        if (to || b.bundle_hv_out !== e.hv || b.item_count !== e.items) begin
            miscompares++;
            $display("FAIL soft_reset_fresh got hv=%h items=%0d exp hv=%h items=%0d",
                     b.bundle_hv_out, b.item_count, e.hv, e.items);
        end
        ack();
    endtask

    task automatic test_rst_in_done();
        bit to;
        b.threshold = 4'd1;
        sb.push_back('{hv: 8'h5A, items: 16'd1});
        send(8'h5A, 1'b1);
        wait_valid(to);
        e = sb.pop_front();
        vectors++;
        if (to || b.bundle_hv_out !== e.hv) begin
            miscompares++;
            $display("FAIL rst_done_setup got hv=%h exp %h", b.bundle_hv_out, e.hv);
        end
        rst_ni = 1'b0;
        b.bundle_ack = 1'b1;
        @(negedge clk);
        rst_ni = 1'b1;
        b.bundle_ack = 1'b0;
        vectors++;
        if (b.bundle_valid !== 1'b0 || b.bundle_hv_out !== 8'h00 || b.busy !== 1'b0 ||
            b.item_count !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_in_done got v=%b hv=%h busy=%b items=%0d exp 0 00 0 0",
                     b.bundle_valid, b.bundle_hv_out, b.busy, b.item_count);
        end
        sb.push_back('{hv: 8'h42, items: 16'd1});
        send(8'h42, 1'b1);
        wait_valid(to);
        e = sb.pop_front();
        vectors++;
        if (to || b.bundle_hv_out !== e.hv || b.item_count !== e.items) begin
            miscompares++;
            $display("FAIL rst_after got hv=%h items=%0d exp hv=%h items=%0d",
                     b.bundle_hv_out, b.item_count, e.hv, e.items);
        end
        ack();
    endtask

    initial begin
        b.bind_hv_in = '0;
        b.bind_valid = 1'b0;
        b.bind_last  = 1'b0;
        b.threshold  = '0;
        b.bundle_ack = 1'b0;
        test_reset();
        test_majority();
        test_saturation();
        test_single();
        test_drop();
        test_soft_reset();
        test_rst_in_done();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
